// File: rtl/version_rom_pkg.sv
//------------------------------------------------------------------------------
// Module   : version_rom_pkg
// Purpose  : Shared types and sizing for the version ROM read sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package version_rom_pkg;

  localparam int VROM_DATA_W = 32;
  localparam int VROM_ADDR_W = 3;
  localparam int VROM_WORDS  = 5;
  // Wide enough for the largest supported read latency (3).
  localparam int VROM_LAT_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/version_rom_reader_if.sv
//------------------------------------------------------------------------------
// Module   : version_rom_reader_if
// Purpose  : Avalon-MM ROM read port plus valid/ready beat stream.
//            master = sequencer side, slave = ROM/consumer side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface version_rom_reader_if
  import version_rom_pkg::*;
#(
  parameter int ADDR_W = VROM_ADDR_W,
  parameter int DATA_W = VROM_DATA_W
);

  // ROM side
  logic [ADDR_W-1:0] rom_address;
  logic              rom_chipselect;
  logic              rom_clken;
  logic [3:0]        rom_byteenable;
  logic              rom_write;
  logic              rom_debugaccess;
  logic [DATA_W-1:0] rom_writedata;
  logic [DATA_W-1:0] rom_readdata;

  // Stream side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output rom_address, rom_chipselect, rom_clken, rom_byteenable,
    output rom_write, rom_debugaccess, rom_writedata,
    input  rom_readdata,
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  rom_address, rom_chipselect, rom_clken, rom_byteenable,
    input  rom_write, rom_debugaccess, rom_writedata,
    output rom_readdata,
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/version_rom_reader.sv
//------------------------------------------------------------------------------
// Module   : version_rom_reader
// Purpose  : On a start pulse, reads ROM words 0..NUM_WORDS-1 one at a time
//            (single outstanding read) and emits each as a stream beat.
//            Optional macro VERSION_ROM_READER_CHECKSUM_EN appends one extra
//            beat carrying the XOR of all words read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module version_rom_reader
  import version_rom_pkg::*;
#(
  parameter int NUM_WORDS    = VROM_WORDS,
  parameter int ADDR_W       = VROM_ADDR_W,
  parameter int DATA_W       = VROM_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            start,
  output logic                 busy,
  output logic                 done,
  version_rom_reader_if.master bus
);

  localparam logic [ADDR_W-1:0]     LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [VROM_LAT_W-1:0] LAT_INIT = VROM_LAT_W'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("version_rom_reader: READ_LATENCY must be 1..3");
  end

`ifdef VERSION_ROM_READER_CHECKSUM_EN
  // The checksum beat reports index NUM_WORDS, which must be addressable.
  localparam logic [ADDR_W-1:0] SUM_IDX = ADDR_W'(NUM_WORDS);
  if (NUM_WORDS >= 2**ADDR_W) begin : g_bad_depth
    $error("version_rom_reader: NUM_WORDS must be < 2**ADDR_W with checksum");
  end
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [VROM_LAT_W-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic                    rom_en_q, rom_en_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [ADDR_W-1:0]       out_index_q, out_index_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state and registered-output decode; every output is a flop so the
  // ROM address/enable are set up one state ahead of the cycle they apply to.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    rom_addr_d  = rom_addr_q;
    rom_en_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef VERSION_ROM_READER_CHECKSUM_EN
    acc_d       = acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          idx_d      = '0;
          rom_addr_d = '0;
          rom_en_d   = 1'b1;
          busy_d     = 1'b1;
`ifdef VERSION_ROM_READER_CHECKSUM_EN
          acc_d      = '0;
`endif
        end
      end

      READ: begin
        state_d  = WAIT;
        lat_d    = LAT_INIT;
        rom_en_d = 1'b1;
      end

      WAIT: begin
        if (lat_q == '0) begin
          // Read data is valid now; capture it and drop the ROM enable so the
          // ROM pipeline holds still while the beat waits for the consumer.
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_data_d  = bus.rom_readdata;
          out_index_d = idx_q;
`ifdef VERSION_ROM_READER_CHECKSUM_EN
          out_last_d  = 1'b0;
          acc_d       = acc_q ^ bus.rom_readdata;
`else
          out_last_d  = (idx_q == LAST_IDX);
`endif
        end else begin
          lat_d    = lat_q - VROM_LAT_W'(1);
          rom_en_d = 1'b1;
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`ifdef VERSION_ROM_READER_CHECKSUM_EN
          else if (idx_q == LAST_IDX) begin
            // Trailing checksum beat: no ROM access, stay in OUT.
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_index_d = SUM_IDX;
            out_last_d  = 1'b1;
          end
`endif
          else begin
            state_d    = READ;
            idx_d      = idx_q + ADDR_W'(1);
            rom_addr_d = idx_q + ADDR_W'(1);
            rom_en_d   = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lat_q       <= '0;
      rom_addr_q  <= '0;
      rom_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      rom_addr_q  <= rom_addr_d;
      rom_en_q    <= rom_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef VERSION_ROM_READER_CHECKSUM_EN
  // Running XOR of every word captured in the current sequence.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`endif

  assign busy                = busy_q;
  assign done                = done_q;
  assign bus.rom_address     = rom_addr_q;
  assign bus.rom_chipselect  = rom_en_q;
  assign bus.rom_clken       = rom_en_q;
  assign bus.rom_byteenable  = 4'hF;
  assign bus.rom_write       = 1'b0;
  assign bus.rom_debugaccess = 1'b0;
  assign bus.rom_writedata   = '0;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_index       = out_index_q;
  assign bus.out_last        = out_last_q;

endmodule

`default_nettype wire
